// File: rtl/uart_cmd_streamer_pkg.sv
// Shared types and constants for the UART command-string streamer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, WAIT, GAP} state_t;

  // Bit periods in clock cycles for a 50 MHz system clock
  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned B115200 = CLK_HZ / 115_200;
  localparam int unsigned B57600  = CLK_HZ / 57_600;
  localparam int unsigned B38400  = CLK_HZ / 38_400;
  localparam int unsigned B19200  = CLK_HZ / 19_200;
  localparam int unsigned B9600   = CLK_HZ / 9_600;
  localparam int unsigned B4800   = CLK_HZ / 4_800;
  localparam int unsigned B2400   = CLK_HZ / 2_400;
  localparam int unsigned B1200   = CLK_HZ / 1_200;
  localparam int unsigned B600    = CLK_HZ / 600;
  localparam int unsigned B300    = CLK_HZ / 300;

  localparam logic [7:0] TERM_DEFAULT = 8'h0A;

endpackage

// File: rtl/uart_cmd_streamer_if.sv
// Request side (index queue) and uart_tx side of the command streamer.
interface uart_cmd_streamer_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic [IDX_W-1:0]  cmd_idx;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_idx, cmd_valid, tx_ready,
    input  cmd_ready, tx_data, tx_start, busy, done, err
  );

  modport slave (
    input  cmd_idx, cmd_valid, tx_ready,
    output cmd_ready, tx_data, tx_start, busy, done, err
  );

endinterface

// File: rtl/uart_cmd_streamer_fifo.sv
// Small synchronous show-ahead FIFO for queued command indices (DEPTH power of 2).
module cmd_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, do_push, do_pop;

  always_comb begin
    do_push     = push && !full;
    do_pop      = pop && !empty;
    count_nxt_c = count + CW'(do_push) - CW'(do_pop);
  end

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_cmd_streamer.sv
// Queued command-string transmitter: index -> address ROM -> byte ROM -> uart_tx,
// terminated by TERM or a length guard, followed by an inter-command gap.
module uart_cmd_streamer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned                          N_CMDS       = 16,
  parameter int unsigned                          ROM_DEPTH    = 128,
  parameter int unsigned                          DATA_W       = 8,
  parameter logic [DATA_W-1:0]                    TERM         = DATA_W'(TERM_DEFAULT),
  parameter int unsigned                          MAX_LEN      = 64,
  parameter int unsigned                          GAP_CYCLES   = 200_000_000,
  parameter int unsigned                          FIFO_DEPTH   = 4,
  parameter logic [ROM_DEPTH*DATA_W-1:0]          CMD_ROM_INIT = '0,
  parameter logic [N_CMDS*$clog2(ROM_DEPTH)-1:0]  ADR_ROM_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_streamer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_CMDS);
  localparam int unsigned PTR_W = $clog2(ROM_DEPTH);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMR_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t              state, state_d;
  logic [PTR_W-1:0]    ptr, ptr_d, adr_ptr;
  logic [LEN_W-1:0]    len, len_d;
  logic [TMR_W-1:0]    tmr, tmr_d;
  logic [DATA_W-1:0]   cur_byte, cur_byte_d, rom_byte;
  logic                seen_low, seen_low_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                str_end, idx_ok;
  logic                fifo_push, fifo_pop, fifo_empty;
  logic [IDX_W-1:0]    fifo_rdata;
  logic [CNT_W-1:0]    fifo_cnt_nxt;

  assign fifo_push = bus.cmd_valid && cmd_ready_q;

  cmd_fifo #(.DATA_W(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .wdata       (bus.cmd_idx),
    .rdata       (fifo_rdata),
    .empty       (fifo_empty),
    .count_nxt_c (fifo_cnt_nxt)
  );

  // ROM lookups; out-of-range indices are steered to slot 0 and rejected by the FSM
  always_comb begin
    idx_ok   = (32'(fifo_rdata) < N_CMDS);
    adr_ptr  = ADR_ROM_INIT[(idx_ok ? 32'(fifo_rdata) : 32'd0) * PTR_W +: PTR_W];
    rom_byte = CMD_ROM_INIT[32'(ptr) * DATA_W +: DATA_W];
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    len_d      = len;
    tmr_d      = tmr;
    cur_byte_d = cur_byte;
    seen_low_d = seen_low;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fifo_pop   = 1'b0;
    str_end    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!idx_ok) begin
            err_d = 1'b1;
          end else begin
            ptr_d   = adr_ptr;
            len_d   = '0;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        cur_byte_d = rom_byte;
        state_d    = FETCH;
      end
      FETCH: begin
        if (bus.tx_ready) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          seen_low_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // The byte is only finished once uart_tx has gone busy and come back
        if (!seen_low) begin
          if (!bus.tx_ready) seen_low_d = 1'b1;
        end else if (bus.tx_ready) begin
          if (cur_byte == TERM) begin
            str_end = 1'b1;
          end else if (len == LEN_W'(MAX_LEN - 1)) begin
            err_d   = 1'b1;
            str_end = 1'b1;
          end else begin
            ptr_d   = (ptr == PTR_W'(ROM_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
            len_d   = len + LEN_W'(1);
            state_d = LOOKUP;
          end
          if (str_end) begin
            if (GAP_CYCLES == 0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              tmr_d   = TMR_W'(GAP_CYCLES - 1);
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (tmr == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE) || (fifo_cnt_nxt != '0);
    cmd_ready_d = (fifo_cnt_nxt != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      len         <= '0;
      tmr         <= '0;
      cur_byte    <= '0;
      seen_low    <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      len         <= len_d;
      tmr         <= tmr_d;
      cur_byte    <= cur_byte_d;
      seen_low    <= seen_low_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_cmd_streamer.sv
// Bench for uart_cmd_streamer: directed commands, a queue-of-events model and a
// per-cycle checker that also plays the part of uart_tx.
module tb_uart_cmd_streamer;

  localparam int unsigned N_CMDS     = 12;
  localparam int unsigned ROM_DEPTH  = 128;
  localparam int unsigned PTR_W      = 7;
  localparam int unsigned MAX_LEN    = 64;
  localparam int unsigned GAP        = 20;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          FRAME      = 4;
  localparam logic [7:0]  TERM       = 8'h0A;

  localparam int EV_BYTE = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  function automatic logic [ROM_DEPTH*8-1:0] build_cmd();
    logic [ROM_DEPTH*8-1:0] img;
    img = '0;
    for (int i = 0; i < 64; i++) img[(64 + i)*8 +: 8] = 8'(8'h61 + i % 26);
    img[0*8 +: 8]  = 8'h57;  img[1*8 +: 8]  = 8'h0A;
    img[16*8 +: 8] = 8'h4F;  img[17*8 +: 8] = 8'h4B;  img[18*8 +: 8] = 8'h0A;
    img[32*8 +: 8] = 8'h41;  img[33*8 +: 8] = 8'h42;  img[34*8 +: 8] = 8'h0A;
    img[36*8 +: 8] = 8'h58;  img[37*8 +: 8] = 8'h0A;
    img[40*8 +: 8] = 8'h48;  img[41*8 +: 8] = 8'h49;  img[42*8 +: 8] = 8'h21;
    img[43*8 +: 8] = 8'h0A;
    img[46*8 +: 8] = 8'h5A;  img[47*8 +: 8] = 8'h0A;
    return img;
  endfunction

  function automatic logic [N_CMDS*PTR_W-1:0] build_adr();
    logic [N_CMDS*PTR_W-1:0] a;
    for (int i = 0; i < int'(N_CMDS); i++) a[i*PTR_W +: PTR_W] = 7'h10;
    a[1*PTR_W +: PTR_W] = 7'h20;
    a[2*PTR_W +: PTR_W] = 7'h10;
    a[3*PTR_W +: PTR_W] = 7'h24;
    a[4*PTR_W +: PTR_W] = 7'h28;
    a[5*PTR_W +: PTR_W] = 7'h2E;
    a[6*PTR_W +: PTR_W] = 7'h40;
    a[7*PTR_W +: PTR_W] = 7'h7E;
    return a;
  endfunction

  localparam logic [ROM_DEPTH*8-1:0]    CMD_IMG = build_cmd();
  localparam logic [N_CMDS*PTR_W-1:0]   ADR_IMG = build_adr();

  typedef struct {
    int         kind;
    logic [7:0] b;
    bit         len_abort;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_streamer_if #(.IDX_W(4), .DATA_W(8)) bus ();

  logic [3:0] drv_idx    = '0;
  logic       drv_valid  = 1'b0;
  logic       uart_ready = 1'b1;
  int         uart_cnt   = 0;

  assign bus.cmd_idx   = drv_idx;
  assign bus.cmd_valid = drv_valid;
  assign bus.tx_ready  = uart_ready;

  uart_cmd_streamer #(
    .N_CMDS       (N_CMDS),
    .ROM_DEPTH    (ROM_DEPTH),
    .DATA_W       (8),
    .TERM         (TERM),
    .MAX_LEN      (MAX_LEN),
    .GAP_CYCLES   (GAP),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CMD_ROM_INIT (CMD_IMG),
    .ADR_ROM_INIT (ADR_IMG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  ev_t        exp_q[$];
  logic [7:0] seen_bytes[$];
  logic [7:0] want[$];
  int         n_starts = 0;
  int         n_err = 0;
  int         rise_cyc = 0;
  int         first_start_cyc = -1;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event sequence for one accepted index, straight from the ROM images
  task automatic model_cmd(input int idx);
    int p;
    logic [7:0] b;
    if (idx >= int'(N_CMDS)) begin
      exp_q.push_back('{EV_ERR, 8'h00, 1'b0});
      return;
    end
    p = int'(ADR_IMG[idx*PTR_W +: PTR_W]);
    for (int n = 0; n < int'(MAX_LEN); n++) begin
      b = CMD_IMG[p*8 +: 8];
      exp_q.push_back('{EV_BYTE, b, 1'b0});
      if (b == TERM) break;
      if (n == int'(MAX_LEN) - 1) exp_q.push_back('{EV_ERR, 8'h00, 1'b1});
      p = (p + 1) % int'(ROM_DEPTH);
    end
    exp_q.push_back('{EV_DONE, 8'h00, 1'b0});
  endtask

  task automatic take(input int kind, input logic [7:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("event_unexpected", kind, 99);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == EV_BYTE && e.kind == EV_BYTE) chk("tx_data", b, e.b);
    if (kind == EV_ERR && e.kind == EV_ERR && e.len_abort) chk("err_len_time", cyc, rise_cyc + 1);
    if (kind == EV_DONE && e.kind == EV_DONE) chk("done_time", cyc, rise_cyc + 1 + GAP);
  endtask

  // Per-cycle checker, then the uart_tx stand-in updates tx_ready
  always @(negedge clk) begin
    if (rst) begin
      uart_ready = 1'b1;
      uart_cnt   = 0;
      prev_data  = '0;
    end else begin
      if (bus.tx_start) begin
        chk("tx_start_while_not_ready", uart_ready, 1);
        n_starts++;
        seen_bytes.push_back(bus.tx_data);
        if (first_start_cyc < 0) first_start_cyc = cyc;
        take(EV_BYTE, bus.tx_data);
      end else if (!uart_ready) begin
        chk("tx_data_stable", bus.tx_data, prev_data);
      end
      if (bus.err) begin
        n_err++;
        take(EV_ERR, 8'h00);
      end
      if (bus.done) take(EV_DONE, 8'h00);
      prev_data = bus.tx_data;
      if (bus.tx_start) begin
        uart_ready = 1'b0;
        uart_cnt   = FRAME;
      end else if (!uart_ready) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          uart_ready = 1'b1;
          rise_cyc   = cyc;
        end
      end
    end
  end

  task automatic push(input logic [3:0] idx, output logic acc);
    drv_idx   = idx;
    drv_valid = 1'b1;
    acc       = bus.cmd_ready;
    @(negedge clk);
    if (acc) model_cmd(int'(idx));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < budget, 1);
    repeat (2) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    chk("busy_after_idle", bus.busy, 0);
  endtask

  task automatic chk_seen(input string name);
    chk({name, "_count"}, seen_bytes.size(), want.size());
    for (int i = 0; i < want.size() && i < seen_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), seen_bytes[i], want[i]);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({name, "_tx_data"},   bus.tx_data,   0);
    chk({name, "_tx_start"},  bus.tx_start,  0);
    chk({name, "_busy"},      bus.busy,      0);
    chk({name, "_done"},      bus.done,      0);
    chk({name, "_err"},       bus.err,       0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic       acc;
    int         acc_cyc;
    int         base_starts, base_err;
    logic [4:0] want_acc;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // 1: idx 2 -> "OK\n", start latency 3 cycles
    seen_bytes.delete();
    first_start_cyc = -1;
    push(4'd2, acc);
    acc_cyc   = cyc;
    drv_valid = 1'b0;
    chk("t1_accept", acc, 1);
    wait_idle(400);
    chk("t1_latency", first_start_cyc - acc_cyc, 3);
    want = '{8'h4F, 8'h4B, 8'h0A};
    chk_seen("t1");

    // 2: fill the queue while a string is in flight
    seen_bytes.delete();
    first_start_cyc = -1;
    push(4'd2, acc);
    drv_valid = 1'b0;
    for (int n = 0; n < 20 && first_start_cyc < 0; n++) @(negedge clk);
    chk("t2_started", first_start_cyc >= 0, 1);
    want_acc = 5'b01111;
    for (int i = 1; i <= 5; i++) begin
      push(4'(i), acc);
      chk($sformatf("t2_accept%0d", i), acc, want_acc[i-1]);
      if (i == 4) chk("t2_ready_full", bus.cmd_ready, 0);
    end
    drv_valid = 1'b0;
    wait_idle(2000);
    chk("t2_total_bytes", seen_bytes.size(), 15);
    chk("t2_ready_back", bus.cmd_ready, 1);

    // 3: out-of-range index, then a normal one
    seen_bytes.delete();
    base_err = n_err;
    push(4'd12, acc);
    push(4'd3, acc);
    drv_valid = 1'b0;
    wait_idle(400);
    chk("t3_err_count", n_err - base_err, 1);
    want = '{8'h58, 8'h0A};
    chk_seen("t3");

    // 4: no terminator within MAX_LEN bytes
    seen_bytes.delete();
    base_starts = n_starts;
    base_err    = n_err;
    push(4'd6, acc);
    drv_valid = 1'b0;
    wait_idle(3000);
    chk("t4_starts", n_starts - base_starts, 64);
    chk("t4_err_count", n_err - base_err, 1);

    // 5: pointer wraps from the top of the byte ROM
    seen_bytes.delete();
    push(4'd7, acc);
    drv_valid = 1'b0;
    wait_idle(400);
    want = '{8'h6B, 8'h6C, 8'h57, 8'h0A};
    chk_seen("t5");

    // 6: reset during the second byte abandons the string and the queue
    base_starts = n_starts;
    push(4'd4, acc);
    push(4'd1, acc);
    drv_valid = 1'b0;
    for (int n = 0; n < 60 && n_starts - base_starts < 2; n++) @(negedge clk);
    chk("t6_second_byte", n_starts - base_starts, 2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1 chk_reset_outputs("t6_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    seen_bytes.delete();
    push(4'd4, acc);
    drv_valid = 1'b0;
    wait_idle(400);
    want = '{8'h48, 8'h49, 8'h21, 8'h0A};
    chk_seen("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
